// File: rtl/emu_check_sched.sv
// Lockstep scheduler: buffers CPU retire entries, runs the emulator once per entry and
// compares the CHECKS-enabled fields, counting pass/fail and reporting mismatches.
module emu_check_sched #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT     = 64,
    parameter bit          HALT_ON_ERR = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        ret_valid_in,
    output logic        ret_ready_out,
    input  logic [31:0] ret_pc_in,
    input  logic        ret_gpr_wr_in,
    input  logic [4:0]  ret_gpr_addr_in,
    input  logic [31:0] ret_gpr_data_in,
    input  logic        ret_exc_in,
    input  logic [1:0]  ret_mode_in,
    output logic        emu_start_out,
    input  logic        emu_done_in,
    input  logic [14:0] emu_checks_in,
    input  logic [31:0] emu_pc_in,
    input  logic        emu_gpr_wr_in,
    input  logic [4:0]  emu_gpr_addr_in,
    input  logic [31:0] emu_gpr_data_in,
    input  logic        emu_exc_in,
    input  logic [1:0]  emu_mode_in,
    input  logic        clr_in,
    output logic        err_valid_out,
    output logic [6:0]  err_mask_out,
    output logic [31:0] err_pc_out,
    output logic        halted_out,
    output logic [31:0] pass_cnt_out,
    output logic [15:0] fail_cnt_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned EW = 73;

    localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMR_ONE  = {{(TW - 1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StWait, StCmp, StHalt} state_e;

    state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [EW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop, flush;

    logic          latch_en, cmp_fire, tmo_fire, mismatch;
    logic [EW-1:0] entry_in, head, emu_q;
    logic [5:0]    chk_q;
    logic [5:0]    mask;

    logic          err_valid_q;
    logic [6:0]    err_mask_q;
    logic [31:0]   err_pc_q;
    logic [31:0]   pass_q;
    logic [15:0]   fail_q;

    logic          unused_checks;
    assign unused_checks = ^{emu_checks_in[13:10], emu_checks_in[6:3], emu_checks_in[1]};

    // Entry layout: pc[72:41] gpr_wr[40] gpr_addr[39:35] gpr_data[34:3] exc[2] mode[1:0]
    assign entry_in = {ret_pc_in, ret_gpr_wr_in, ret_gpr_addr_in, ret_gpr_data_in,
                       ret_exc_in, ret_mode_in};
    assign head     = fifo_mem[rd_ptr_q];

    assign full          = (count_q == FULL_CNT);
    assign empty         = (count_q == '0);
    assign push          = ret_valid_in & ~full;
    assign ret_ready_out = ~full;
    assign emu_start_out = (state_q == StStart);
    assign halted_out    = (state_q == StHalt);

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= entry_in;
        end
    end

    // A push arriving in the flush cycle survives as the new head.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = {{AW{1'b0}}, push};
        end else if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Address and data only count when the emulator says a GPR was written.
    always_comb begin
        mask[0] = chk_q[5] & (emu_q[72:41] != head[72:41]);
        mask[1] = chk_q[4] & (emu_q[40] != head[40]);
        mask[2] = chk_q[3] & emu_q[40] & (emu_q[39:35] != head[39:35]);
        mask[3] = chk_q[2] & emu_q[40] & (emu_q[34:3] != head[34:3]);
        mask[4] = chk_q[1] & (emu_q[2] != head[2]);
        mask[5] = chk_q[0] & (emu_q[1:0] != head[1:0]);
    end
    assign mismatch = |mask;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        flush    = 1'b0;
        latch_en = 1'b0;
        cmp_fire = 1'b0;
        tmo_fire = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
                timer_d = '0;
            end
            StWait: begin
                timer_d = timer_q + TMR_ONE;
                if (emu_done_in) begin
                    latch_en = 1'b1;
                    state_d  = StCmp;
                end else if (timer_q == TMR_LAST) begin
                    tmo_fire = 1'b1;
                    pop      = 1'b1;
                    state_d  = StHalt;
                end
            end
            StCmp: begin
                pop      = 1'b1;
                cmp_fire = 1'b1;
                state_d  = (mismatch && HALT_ON_ERR) ? StHalt : StIdle;
            end
            StHalt: begin
                if (clr_in) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= StIdle;
            timer_q <= '0;
            emu_q   <= '0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (latch_en) begin
                emu_q <= {emu_pc_in, emu_gpr_wr_in, emu_gpr_addr_in, emu_gpr_data_in,
                          emu_exc_in, emu_mode_in};
                chk_q <= {emu_checks_in[14], emu_checks_in[9], emu_checks_in[8],
                          emu_checks_in[7], emu_checks_in[2], emu_checks_in[0]};
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            err_valid_q <= 1'b0;
            err_mask_q  <= '0;
            err_pc_q    <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
        end else begin
            err_valid_q <= tmo_fire | (cmp_fire & mismatch);
            if (tmo_fire) begin
                err_mask_q <= 7'h40;
                err_pc_q   <= head[72:41];
            end else if (cmp_fire && mismatch) begin
                err_mask_q <= {1'b0, mask};
                err_pc_q   <= head[72:41];
            end
            if (cmp_fire && !mismatch && pass_q != '1) begin
                pass_q <= pass_q + 32'd1;
            end
            if ((tmo_fire || (cmp_fire && mismatch)) && fail_q != '1) begin
                fail_q <= fail_q + 16'd1;
            end
        end
    end

    assign err_valid_out = err_valid_q;
    assign err_mask_out  = err_mask_q;
    assign err_pc_out    = err_pc_q;
    assign pass_cnt_out  = pass_q;
    assign fail_cnt_out  = fail_q;

endmodule

// File: tb/tb_emu_check_sched.sv
// Bench for emu_check_sched: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-and-timestamp model of the scheduler.
module tb_emu_check_sched;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam bit HOE     = 1'b1;

    logic        clk_in, reset_n_in;
    logic        ret_valid_in, ret_ready_out;
    logic [31:0] ret_pc_in;
    logic        ret_gpr_wr_in;
    logic [4:0]  ret_gpr_addr_in;
    logic [31:0] ret_gpr_data_in;
    logic        ret_exc_in;
    logic [1:0]  ret_mode_in;
    logic        emu_start_out, emu_done_in;
    logic [14:0] emu_checks_in;
    logic [31:0] emu_pc_in;
    logic        emu_gpr_wr_in;
    logic [4:0]  emu_gpr_addr_in;
    logic [31:0] emu_gpr_data_in;
    logic        emu_exc_in;
    logic [1:0]  emu_mode_in;
    logic        clr_in;
    logic        err_valid_out;
    logic [6:0]  err_mask_out;
    logic [31:0] err_pc_out;
    logic        halted_out;
    logic [31:0] pass_cnt_out;
    logic [15:0] fail_cnt_out;

    emu_check_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .HALT_ON_ERR(HOE)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .ret_valid_in(ret_valid_in), .ret_ready_out(ret_ready_out),
        .ret_pc_in(ret_pc_in), .ret_gpr_wr_in(ret_gpr_wr_in),
        .ret_gpr_addr_in(ret_gpr_addr_in), .ret_gpr_data_in(ret_gpr_data_in),
        .ret_exc_in(ret_exc_in), .ret_mode_in(ret_mode_in),
        .emu_start_out(emu_start_out), .emu_done_in(emu_done_in),
        .emu_checks_in(emu_checks_in), .emu_pc_in(emu_pc_in),
        .emu_gpr_wr_in(emu_gpr_wr_in), .emu_gpr_addr_in(emu_gpr_addr_in),
        .emu_gpr_data_in(emu_gpr_data_in), .emu_exc_in(emu_exc_in),
        .emu_mode_in(emu_mode_in), .clr_in(clr_in),
        .err_valid_out(err_valid_out), .err_mask_out(err_mask_out),
        .err_pc_out(err_pc_out), .halted_out(halted_out),
        .pass_cnt_out(pass_cnt_out), .fail_cnt_out(fail_cnt_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic        gwr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        exc;
        logic [1:0]  mode;
    } ent_t;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Model: FIFO contents, in-flight entry timestamps, halt flag and registered outputs.
    ent_t        q[$];
    bit          busy, m_halt, m_errv;
    int          start_at, done_at;
    logic [6:0]  m_mask;
    logic [31:0] m_pc, m_pass;
    logic [15:0] m_fail;
    ent_t        lat;
    logic [14:0] lat_chk;

    bit          rnd_mode;
    bit          d_valid, d_clr, d_done;
    ent_t        d_ent, e_ent;
    logic [14:0] e_chk;
    int          plan_delay, plan_mut, dir_delay, dir_mut;
    logic [14:0] plan_chk, dir_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] cmp_mask(ent_t r, ent_t e, logic [14:0] c);
        logic [6:0] m;
        m    = '0;
        m[0] = c[14] && (e.pc != r.pc);
        m[1] = c[9] && (e.gwr != r.gwr);
        m[2] = c[8] && e.gwr && (e.addr != r.addr);
        m[3] = c[7] && e.gwr && (e.data != r.data);
        m[4] = c[2] && (e.exc != r.exc);
        m[5] = c[0] && (e.mode != r.mode);
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        busy = 0; m_halt = 0; m_errv = 0;
        start_at = -10; done_at = -1;
        m_mask = '0; m_pc = '0; m_pass = '0; m_fail = '0;
    endtask

    task automatic model_step();
        bit         pop, flush;
        int         sz;
        logic [6:0] m;
        pop = 0; flush = 0; sz = q.size();
        m_errv = 0;
        if (busy) begin
            if (done_at < 0 && d_done && cyc > start_at && cyc <= start_at + TIMEOUT) begin
                done_at = cyc; lat = e_ent; lat_chk = e_chk;
            end else if (done_at < 0 && cyc == start_at + TIMEOUT) begin
                pop = 1; m_errv = 1; m_mask = 7'h40; m_pc = q[0].pc; m_halt = 1; busy = 0;
                if (m_fail != 16'hFFFF) m_fail++;
            end else if (done_at >= 0 && cyc == done_at + 1) begin
                m = cmp_mask(q[0], lat, lat_chk);
                pop = 1; busy = 0;
                if (m != 0) begin
                    m_errv = 1; m_mask = m; m_pc = q[0].pc;
                    if (m_fail != 16'hFFFF) m_fail++;
                    if (HOE) m_halt = 1;
                end else if (m_pass != 32'hFFFF_FFFF) begin
                    m_pass++;
                end
            end
        end else if (m_halt) begin
            if (d_clr) begin flush = 1; m_halt = 0; end
        end else if (sz > 0) begin
            busy = 1; start_at = cyc + 1; done_at = -1;
        end
        if (flush) q.delete();
        else if (pop) void'(q.pop_front());
        if (d_valid && sz < DEPTH) q.push_back(d_ent);
    endtask

    task automatic gen_inputs();
        int r;
        e_ent.pc = $urandom; e_ent.gwr = 1'($urandom); e_ent.addr = 5'($urandom);
        e_ent.data = $urandom; e_ent.exc = 1'($urandom); e_ent.mode = 2'($urandom);
        e_chk = 15'($urandom);
        d_done = 1'b0;
        if (rnd_mode) begin
            d_valid = ($urandom % 3) != 0;
            d_ent.pc = $urandom & 32'hFFFF_FFFC; d_ent.gwr = 1'($urandom);
            d_ent.addr = 5'($urandom); d_ent.data = $urandom;
            d_ent.exc = ($urandom % 8) == 0; d_ent.mode = 2'($urandom);
            d_clr = m_halt ? (($urandom % 6) == 0) : (($urandom % 40) == 0);
        end
        if (busy && cyc == start_at) begin
            if (rnd_mode) begin
                r = int'($urandom % 10);
                plan_delay = (r == 0) ? 1000 : (r == 1) ? TIMEOUT : int'($urandom_range(1, 6));
                plan_mut = int'($urandom % 4);
                plan_chk = ($urandom % 2 == 0) ? 15'h7FFF : 15'($urandom);
            end else begin
                plan_delay = (dir_delay == 0) ? 1000 : dir_delay;
                plan_mut = dir_mut; plan_chk = dir_chk;
            end
        end
        if (busy && done_at < 0 && cyc == start_at + plan_delay) begin
            d_done = 1'b1; e_ent = q[0]; e_chk = plan_chk;
            case (plan_mut)
                1: e_ent.data = 32'h5;
                2: begin e_ent.gwr = 1'b0; e_ent.addr = q[0].addr ^ 5'h1; end
                3: case ($urandom % 6)
                       0: e_ent.pc = e_ent.pc ^ 32'h4;
                       1: e_ent.gwr = ~e_ent.gwr;
                       2: e_ent.addr = e_ent.addr ^ 5'h1;
                       3: e_ent.data = e_ent.data ^ (32'h1 << ($urandom % 32));
                       4: e_ent.exc = ~e_ent.exc;
                       default: e_ent.mode = e_ent.mode ^ 2'h1;
                   endcase
                default: ;
            endcase
        end else if (rnd_mode && ($urandom % 20) == 0) begin
            d_done = 1'b1;
        end
    endtask

    task automatic drive();
        ret_valid_in = d_valid; ret_pc_in = d_ent.pc; ret_gpr_wr_in = d_ent.gwr;
        ret_gpr_addr_in = d_ent.addr; ret_gpr_data_in = d_ent.data;
        ret_exc_in = d_ent.exc; ret_mode_in = d_ent.mode; clr_in = d_clr;
        emu_done_in = d_done; emu_checks_in = e_chk; emu_pc_in = e_ent.pc;
        emu_gpr_wr_in = e_ent.gwr; emu_gpr_addr_in = e_ent.addr;
        emu_gpr_data_in = e_ent.data; emu_exc_in = e_ent.exc; emu_mode_in = e_ent.mode;
    endtask

    // Called just after a falling edge: compare this cycle, then advance one clock.
    task automatic tick();
        gen_inputs();
        drive();
        chk("start", emu_start_out, busy && cyc == start_at);
        chk("ready", ret_ready_out, q.size() < DEPTH);
        chk("halted", halted_out, m_halt);
        chk("err_valid", err_valid_out, m_errv);
        chk("err_mask", err_mask_out, m_mask);
        chk("err_pc", err_pc_out, m_pc);
        chk("pass_cnt", pass_cnt_out, m_pass);
        chk("fail_cnt", fail_cnt_out, m_fail);
        model_step();
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic push_ent(input logic [31:0] pc, input logic gwr, input logic [4:0] addr,
                            input logic [31:0] data);
        d_ent.pc = pc; d_ent.gwr = gwr; d_ent.addr = addr; d_ent.data = data;
        d_ent.exc = 1'b0; d_ent.mode = 2'd3;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, ret_ready_out, 1);
        chk({tag, "_start"}, emu_start_out, 0);
        chk({tag, "_halted"}, halted_out, 0);
        chk({tag, "_errv"}, err_valid_out, 0);
        chk({tag, "_mask"}, err_mask_out, 0);
        chk({tag, "_pc"}, err_pc_out, 0);
        chk({tag, "_pass"}, pass_cnt_out, 0);
        chk({tag, "_fail"}, fail_cnt_out, 0);
    endtask

    initial begin
        int s0, guard;
        reset_n_in = 1'b0;
        rnd_mode = 0; d_valid = 0; d_clr = 0; d_done = 0;
        d_ent = '{default: '0}; e_ent = '{default: '0}; e_chk = '0;
        dir_delay = 1; dir_mut = 0; dir_chk = 15'h7FFF;
        plan_delay = 1000; plan_mut = 0; plan_chk = '0;
        drive();
        model_reset();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        chk_reset_outputs("rst");

        // Single clean entry: start two cycles after the handshake, counted as a pass.
        push_ent(32'h100, 1'b1, 5'd3, 32'h6);
        chk("b_start_t1", emu_start_out, 0);
        tick();
        chk("b_start_t2", emu_start_out, 1);
        repeat (3) tick();
        chk("b_pass", pass_cnt_out, 1);
        chk("b_errv", err_valid_out, 0);

        // GPR data 5 vs 6 with only checks[7] set.
        dir_mut = 1; dir_chk = 15'h0080;
        push_ent(32'h200, 1'b1, 5'd4, 32'h6);
        repeat (4) tick();
        chk("c_errv", err_valid_out, 1);
        chk("c_mask", err_mask_out, 7'h08);
        chk("c_pc", err_pc_out, 32'h200);
        chk("c_halt", halted_out, 1);
        chk("c_fail", fail_cnt_out, 1);
        d_clr = 1; tick(); d_clr = 0; tick();
        chk("c_unhalt", halted_out, 0);

        // Same data mismatch with checks[7] clear passes; error registers hold.
        dir_chk = 15'h7F7F;
        push_ent(32'h300, 1'b1, 5'd4, 32'h6);
        repeat (4) tick();
        chk("c2_pass", pass_cnt_out, 2);
        chk("c2_mask_hold", err_mask_out, 7'h08);
        chk("c2_pc_hold", err_pc_out, 32'h200);

        // No GPR write on the emulator side: address difference ignored.
        dir_mut = 2; dir_chk = 15'h7FFF;
        push_ent(32'h400, 1'b0, 5'd3, 32'h77);
        repeat (4) tick();
        chk("d_pass", pass_cnt_out, 3);
        chk("d_errv", err_valid_out, 0);

        // Timeout: emulator never answers.
        dir_mut = 0; dir_delay = 0;
        push_ent(32'h500, 1'b1, 5'd1, 32'h1);
        tick();
        chk("e_start", emu_start_out, 1);
        s0 = cyc;
        while (cyc < s0 + TIMEOUT) tick();
        chk("e_no_err_yet", err_valid_out, 0);
        chk("e_no_halt_yet", halted_out, 0);
        tick();
        chk("e_errv", err_valid_out, 1);
        chk("e_mask", err_mask_out, 7'h40);
        chk("e_pc", err_pc_out, 32'h500);
        chk("e_halt", halted_out, 1);
        chk("e_fail", fail_cnt_out, 2);

        // Three entries queued while halted, then clear.
        push_ent(32'h600, 1'b1, 5'd1, 32'h1);
        push_ent(32'h604, 1'b1, 5'd1, 32'h1);
        push_ent(32'h608, 1'b1, 5'd1, 32'h1);
        chk("h_still_halt", halted_out, 1);
        d_clr = 1; tick(); d_clr = 0;
        repeat (3) tick();
        chk("h_no_start", emu_start_out, 0);
        chk("h_idle", halted_out, 0);
        chk("h_pass_kept", pass_cnt_out, 3);
        chk("h_fail_kept", fail_cnt_out, 2);

        // Fill with a stalled emulator: four accepted, the fifth refused.
        for (int i = 0; i < 5; i++) begin
            chk("f_ready", ret_ready_out, (i < DEPTH) ? 1 : 0);
            d_ent.pc = 32'h700 + 32'(4 * i); d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0;
        guard = 0;
        while (halted_out !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        chk("f_halt_bound", halted_out, 1);
        chk("f_reopen", ret_ready_out, 1);
        chk("f_pc", err_pc_out, 32'h700);
        chk("f_fail", fail_cnt_out, 3);
        push_ent(32'h800, 1'b1, 5'd2, 32'h2);
        chk("f_full_again", ret_ready_out, 0);
        d_clr = 1; tick(); d_clr = 0; tick();
        chk("f_flushed", ret_ready_out, 1);

        // Reset asserted while waiting on the emulator.
        push_ent(32'h900, 1'b1, 5'd2, 32'h2);
        repeat (3) tick();
        reset_n_in = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        cyc++;
        dir_delay = 1;
        push_ent(32'hA00, 1'b1, 5'd2, 32'h2);
        repeat (5) tick();
        chk("g_pass", pass_cnt_out, 1);

        rnd_mode = 1;
        repeat (4000) tick();
        rnd_mode = 0; d_valid = 0; d_clr = 0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
